// File: rtl/goertzel_frame_ctrl.sv
// goertzel_frame_ctrl: frames ADC samples into a fixed-bin Goertzel IIR and captures X(k) on AXI4-S.
// Define GOERTZEL_CTRL_TAG_EN to prepend an 8-bit wrapping frame index to m_axis_tdata.
module goertzel_frame_ctrl #(
    parameter int N   = 126,
    parameter int OW  = 20,
    parameter int CW  = 16,
    parameter int TMO = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic            o_iir_ce,
    output logic            o_iir_clr,
    output logic            o_iir_last,
    input  logic [2*OW-1:0] i_iir_result,
    input  logic            i_iir_done,
`ifdef GOERTZEL_CTRL_TAG_EN
    output logic [2*OW+7:0] m_axis_tdata,
`else
    output logic [2*OW-1:0] m_axis_tdata,
`endif
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [CW-1:0]   o_frame_cnt,
    output logic [CW-1:0]   o_drop_cnt,
    output logic            o_tmo_err,
    output logic            o_busy
);
    localparam int NW = $clog2(N);
    localparam int TW = $clog2(TMO);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_WAIT} state_t;

    state_t          r_state;
    logic [NW-1:0]   r_n;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_hs;
    logic            w_done;
    logic            w_load;
`ifdef GOERTZEL_CTRL_TAG_EN
    logic [7:0]      r_tag;
`endif

    assign s_axis_tready = r_state == S_RUN;
    assign o_iir_ce      = s_axis_tvalid & s_axis_tready;
    assign o_iir_clr     = r_state == S_CLEAR;
    assign o_iir_last    = o_iir_ce & (r_n == N_LAST);
    assign o_busy        = r_state != S_IDLE;
    assign w_hs          = m_axis_tvalid & m_axis_tready;
    assign w_done        = (r_state == S_WAIT) & i_iir_done;
    // a full register may still take a new result if it is being drained this cycle
    assign w_load        = w_done & (~m_axis_tvalid | w_hs);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_tmo_cnt     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            o_frame_cnt   <= '0;
            o_drop_cnt    <= '0;
            o_tmo_err     <= 1'b0;
`ifdef GOERTZEL_CTRL_TAG_EN
            r_tag         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE:  if (i_enable) r_state <= S_CLEAR;
                S_CLEAR: begin
                    r_n       <= '0;
                    r_tmo_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: if (o_iir_ce) begin
                    if (r_n == N_LAST) r_state <= S_WAIT;
                    else r_n <= r_n + 1'b1;
                end
                S_WAIT: if (i_iir_done || r_tmo_cnt == T_LAST) begin
                    r_state   <= i_enable ? S_CLEAR : S_IDLE;
                    o_tmo_err <= o_tmo_err | ~i_iir_done;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_load) begin
`ifdef GOERTZEL_CTRL_TAG_EN
                m_axis_tdata <= {r_tag, i_iir_result};
`else
                m_axis_tdata <= i_iir_result;
`endif
                m_axis_tvalid <= 1'b1;
            end else if (w_hs) begin
                m_axis_tvalid <= 1'b0;
            end
            if (w_done) begin
                o_frame_cnt <= (o_frame_cnt == '1) ? o_frame_cnt : o_frame_cnt + 1'b1;
                if (!w_load) o_drop_cnt <= (o_drop_cnt == '1) ? o_drop_cnt : o_drop_cnt + 1'b1;
`ifdef GOERTZEL_CTRL_TAG_EN
                r_tag <= r_tag + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// tb_goertzel_frame_ctrl: randomized scoreboard bench for goertzel_frame_ctrl (N=6, CW=4, TMO=8).
module tb_goertzel_frame_ctrl;
    localparam int N = 6, OW = 20, CW = 4, TMO = 8;
`ifdef GOERTZEL_CTRL_TAG_EN
    localparam int DW = 2*OW + 8;
`else
    localparam int DW = 2*OW;
`endif
    localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_WAIT = 3;
    localparam int SAT = 2**CW - 1;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, tv = 1'b0, done = 1'b0, trdy = 1'b0;
    logic [2*OW-1:0] res = '0;
    logic tready, ce, clr, last, tvalid, tmo, busy;
    logic [DW-1:0] tdata;
    logic [CW-1:0] fcnt, dcnt;

    always #5 clk = ~clk;

    goertzel_frame_ctrl #(.N(N), .OW(OW), .CW(CW), .TMO(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .s_axis_tvalid(tv), .s_axis_tready(tready),
        .o_iir_ce(ce), .o_iir_clr(clr), .o_iir_last(last),
        .i_iir_result(res), .i_iir_done(done),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(trdy),
        .o_frame_cnt(fcnt), .o_drop_cnt(dcnt), .o_tmo_err(tmo), .o_busy(busy)
    );

    int total = 0, bad = 0;
    bit started = 1'b0;
    // reference model: frame phase, samples taken, cycles waited, output occupancy
    int ph = P_IDLE, acc = 0, wt = 0, frames = 0, drops = 0, dly = 0;
    bit full = 1'b0, tmo_m = 1'b0, zero_td = 1'b1;
    logic [7:0] tag = '0;
    logic [DW-1:0] q[$];
    // stimulus knobs
    int tvp = 0, rdp = 0, dmin = 0, dmax = 1, rstp = 0;
    bit fixed = 1'b0, force_rst = 1'b1, rand_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("tready", 64'(tready), 64'(ph == P_RUN));
        chk("ce", 64'(ce), 64'(tv && ph == P_RUN));
        chk("last", 64'(last), 64'(tv && ph == P_RUN && acc == N-1));
        chk("clr", 64'(clr), 64'(ph == P_CLR));
        chk("busy", 64'(busy), 64'(ph != P_IDLE));
        chk("tvalid", 64'(tvalid), 64'(full));
        chk("frame_cnt", 64'(fcnt), 64'(frames));
        chk("drop_cnt", 64'(dcnt), 64'(drops));
        chk("tmo_err", 64'(tmo), 64'(tmo_m));
        if (zero_td) chk("tdata_rst", 64'(tdata), 64'd0);
        if (full) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty actual=%0h required=none", tdata);
            end else begin
                chk("tdata", 64'(tdata), 64'(q[0]));
                if (trdy) void'(q.pop_front());
            end
        end
    end

    task automatic model_update();
        bit hs;
        if (rst) begin
            ph = P_IDLE; acc = 0; wt = 0; frames = 0; drops = 0;
            full = 1'b0; tmo_m = 1'b0; zero_td = 1'b1; tag = '0; q.delete();
        end else begin
            hs = full && trdy;
            if (ph == P_WAIT && done) begin
                frames = (frames == SAT) ? frames : frames + 1;
                if (!full || hs) begin
`ifdef GOERTZEL_CTRL_TAG_EN
                    q.push_back({tag, res});
`else
                    q.push_back(res);
`endif
                    full = 1'b1;
                    zero_td = 1'b0;
                end else begin
                    drops = (drops == SAT) ? drops : drops + 1;
                end
                tag = tag + 8'd1;
            end else if (hs) begin
                full = 1'b0;
            end
            case (ph)
                P_IDLE: if (en) ph = P_CLR;
                P_CLR: begin acc = 0; ph = P_RUN; end
                P_RUN: if (tv) begin
                    acc++;
                    if (acc == N) begin
                        ph = P_WAIT; wt = 0; dly = $urandom_range(dmax, dmin);
                    end
                end
                default: if (done) ph = en ? P_CLR : P_IDLE;
                else begin
                    wt++;
                    if (wt == TMO) begin tmo_m = 1'b1; ph = en ? P_CLR : P_IDLE; end
                end
            endcase
        end
    endtask

    task automatic step();
        rst  = force_rst || ($urandom_range(0, 999) < rstp);
        if (rand_en) en = $urandom_range(0, 99) < 70;
        tv   = $urandom_range(0, 99) < tvp;
        trdy = $urandom_range(0, 99) < rdp;
        res  = fixed ? 40'h12345_6789A : {8'($urandom()), 32'($urandom())};
        done = (ph == P_WAIT) ? (wt == dly) : ($urandom_range(0, 99) < 3);
        @(posedge clk);
        model_update();
        #1;
        started = 1'b1;
    endtask

    initial begin
        repeat (3) step();
        force_rst = 1'b0;
        en = 1'b1; tvp = 100; rdp = 100; dmin = 1; dmax = 1; fixed = 1'b1;
        repeat (12) step();
        fixed = 1'b0; rdp = 0; dmin = 0; dmax = 3;
        repeat (40) step();
        rdp = 100;
        repeat (3) step();
        rdp = 50; tvp = 70;
        repeat (300) step();
        rdp = 0;
        repeat (200) step();
        rdp = 60; rand_en = 1'b1;
        repeat (400) step();
        dmax = TMO + 2;
        repeat (400) step();
        rstp = 10;
        repeat (800) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
